// File: rtl/msg_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : msg_arbiter
//  Purpose  : Shares one message-log sink among N_REQ requesters.
//             - Round-robin grant of graded message records.
//             - Records below the severity threshold are dropped.
//             - Saturating per-type and drop counters.
//             - STOP/EXIT actions produce sticky stop/exit requests.
//  Revision : 1.0 - initial release
// ============================================================================
module msg_arbiter #(
    parameter int N_REQ  = 4,
    parameter int CODE_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           req_valid,
    output logic [N_REQ-1:0]           req_ready,
    input  logic [2*N_REQ-1:0]         req_type,
    input  logic [2*N_REQ-1:0]         req_svrt,
    input  logic [2*N_REQ-1:0]         req_act,
    input  logic [CODE_W*N_REQ-1:0]    req_code,
    input  logic [1:0]                 svrt_thold,
    input  logic                       resume,
    input  logic                       clear,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(N_REQ)-1:0]   out_src,
    output logic [1:0]                 out_type,
    output logic [1:0]                 out_svrt,
    output logic [1:0]                 out_act,
    output logic [CODE_W-1:0]          out_code,
    output logic [CNT_W-1:0]           cnt_info,
    output logic [CNT_W-1:0]           cnt_warn,
    output logic [CNT_W-1:0]           cnt_error,
    output logic [CNT_W-1:0]           cnt_fatal,
    output logic [CNT_W-1:0]           cnt_drop,
    output logic                       stop_req,
    output logic                       exit_req
);

    localparam int c_SRC_W = $clog2(N_REQ);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_SEND  = 2'd1;
    localparam logic [1:0] c_ST_PAUSE = 2'd2;
    localparam logic [1:0] c_ST_HALT  = 2'd3;

    localparam logic [1:0] c_ACT_STOP = 2'd1;
    localparam logic [1:0] c_ACT_EXIT = 2'd2;

    // counter slots: 0..3 per message type, 4 for threshold drops
    localparam int c_N_CNT  = 5;
    localparam int c_IX_DRP = 4;

    logic [1:0]          r_state;
    logic [1:0]          w_state_nxt;
    logic [c_SRC_W-1:0]  r_ptr;
    logic [c_SRC_W-1:0]  w_gnt_idx;
    logic                w_gnt_found;
    logic                w_accept;
    logic                w_pass;
    logic [1:0]          w_sel_type;
    logic [1:0]          w_sel_svrt;
    logic [1:0]          w_sel_act;
    logic [CODE_W-1:0]   w_sel_code;
    logic [c_N_CNT-1:0]  w_inc;
    logic [CNT_W-1:0]    r_cnt [c_N_CNT];

    // (base + off) modulo N_REQ, valid for off < N_REQ
    function automatic logic [c_SRC_W-1:0] f_wrap(input logic [c_SRC_W-1:0] base,
                                                  input int off);
        int sum;
        sum = int'(base) + off;
        if (sum >= N_REQ) sum = sum - N_REQ;
        return c_SRC_W'(sum);
    endfunction

    // state entered once a message's action takes effect; code 3 acts as LOG
    function automatic logic [1:0] f_act_state(input logic [1:0] act);
        logic [1:0] st;
        st = c_ST_IDLE;
        if (act == c_ACT_STOP) st = c_ST_PAUSE;
        if (act == c_ACT_EXIT) st = c_ST_HALT;
        return st;
    endfunction

    // Round-robin search: first valid requester at or after the pointer
    always_comb begin
        w_gnt_found = 1'b0;
        w_gnt_idx   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!w_gnt_found && req_valid[f_wrap(r_ptr, k)]) begin
                w_gnt_found = 1'b1;
                w_gnt_idx   = f_wrap(r_ptr, k);
            end
        end
    end

    assign w_accept   = (r_state == c_ST_IDLE) && w_gnt_found && !rst;
    assign w_sel_type = req_type[int'(w_gnt_idx)*2 +: 2];
    assign w_sel_svrt = req_svrt[int'(w_gnt_idx)*2 +: 2];
    assign w_sel_act  = req_act[int'(w_gnt_idx)*2 +: 2];
    assign w_sel_code = req_code[int'(w_gnt_idx)*CODE_W +: CODE_W];
    assign w_pass     = (w_sel_svrt >= svrt_thold);

    // One-hot ready toward the granted requester, only while accepting
    always_comb begin
        req_ready = '0;
        if (w_accept) req_ready[w_gnt_idx] = 1'b1;
    end

    // Next-state decode
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (w_accept) w_state_nxt = w_pass ? c_ST_SEND : f_act_state(w_sel_act);
            end
            c_ST_SEND: begin
                if (out_ready) w_state_nxt = f_act_state(out_act);
            end
            c_ST_PAUSE: begin
                if (resume) w_state_nxt = c_ST_IDLE;
            end
            c_ST_HALT: begin
                w_state_nxt = c_ST_HALT;
            end
            default: w_state_nxt = c_ST_IDLE;
        endcase
    end

    // State and round-robin pointer registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) r_ptr <= f_wrap(w_gnt_idx, 1);
        end
    end

    // Latch the accepted record; it is held stable through SEND
    always_ff @(posedge clk) begin
        if (rst) begin
            out_src  <= '0;
            out_type <= '0;
            out_svrt <= '0;
            out_act  <= '0;
            out_code <= '0;
        end else if (w_accept) begin
            out_src  <= w_gnt_idx;
            out_type <= w_sel_type;
            out_svrt <= w_sel_svrt;
            out_act  <= w_sel_act;
            out_code <= w_sel_code;
        end
    end

    // Counter increment requests for this cycle's accept
    always_comb begin
        w_inc = '0;
        for (int t = 0; t < 4; t++) begin
            w_inc[t] = w_accept && (w_sel_type == 2'(t));
        end
        w_inc[c_IX_DRP] = w_accept && !w_pass;
    end

    // Saturating counters; clear takes priority over a same-cycle increment
    always_ff @(posedge clk) begin
        for (int i = 0; i < c_N_CNT; i++) begin
            if (rst || clear) begin
                r_cnt[i] <= '0;
            end else if (w_inc[i] && (r_cnt[i] != {CNT_W{1'b1}})) begin
                r_cnt[i] <= r_cnt[i] + CNT_W'(1);
            end
        end
    end

    assign cnt_info  = r_cnt[0];
    assign cnt_warn  = r_cnt[1];
    assign cnt_error = r_cnt[2];
    assign cnt_fatal = r_cnt[3];
    assign cnt_drop  = r_cnt[c_IX_DRP];

    assign out_valid = (r_state == c_ST_SEND);
    assign stop_req  = (r_state == c_ST_PAUSE);
    assign exit_req  = (r_state == c_ST_HALT);

endmodule
`default_nettype wire
